servo_cmd: RTL and testbench
============================

# servo_cmd

Command front end for one servo channel of the arm. Accepts angle/speed commands over a valid/ready handshake, converts the angle to a 50 MHz-count high-time target and drives the `duty_need`/`duty_gap` inputs of the downstream pwm stage. It holds off new commands until the ramping stage has had time to reach the target, so the arm sequencer can issue poses back to back.

## Interface
Parameters:
- DUTY_MIN, 25_000 — high-time count for 0° (0.5 ms at 50 MHz).
- DUTY_PER_DEG, 555 — counts added per degree.
- ANGLE_RST, 90 — angle whose duty is driven out of reset.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_angle  in  8  target angle in degrees; legal range 0..180.
- cmd_speed  in  12  counts between unit steps of the downstream ramp; 0 is treated as 1.
- duty_need  out  20  target high time to the pwm stage.
- duty_gap  out  12  ramp step interval to the pwm stage.
- busy  out  1  motion in progress.
- done  out  1  one-cycle pulse when the expected travel time has elapsed.
- err  out  1  last accepted command was out of range; held until the next acceptance.

## Operation
- States: IDLE, LOAD, MOVE.
- IDLE
  - cmd_ready=1, busy=0.
  - On cmd_valid&cmd_ready, latch angle and speed, then go to LOAD.
- LOAD (1 cycle)
  - Angle >180 is clamped to 180 and err is set; otherwise err is cleared.
  - new_duty = DUTY_MIN + angle*DUTY_PER_DEG.
  - duty_need <= new_duty; duty_gap <= max(speed,1).
  - travel = |new_duty − old duty_need| * duty_gap (20×12 → 32-bit unsigned, no truncation). Load it into the counter, then go to MOVE.
- MOVE
  - busy=1, cmd_ready=0.
  - If cnt==0: go to IDLE and pulse done. Otherwise cnt−1.
- cmd_valid while not ready is ignored. The command is not queued.

## Timing
- Reset values:
  - cmd_ready=1, busy=0, done=0, err=0.
  - duty_need = DUTY_MIN + ANGLE_RST*DUTY_PER_DEG (74_950 at defaults).
  - duty_gap=1, cnt=0, state IDLE.
- Handshake at edge k: duty_need/duty_gap change at edge k+1. Edge k+1 is also the edge at which the block enters MOVE; busy=1 from edge k+1.
- done and cmd_ready go high at edge k+2+travel. done lasts one cycle.
- Zero travel (same angle): done at edge k+2.
- Back-to-back: a command held valid is accepted in the first cycle cmd_ready=1. That is the same cycle as done.
- Reset asserted mid-MOVE: all outputs return to reset values at the next edge. No done pulse.
- Counter max ≈ 100_000*4095 < 2^32, so it cannot wrap.

## Configuration
- SERVO_SETTLE_WAIT_EN
  - Defined: behaviour as above.
  - Undefined: no travel counter. MOVE always lasts one cycle, so done and cmd_ready return at edge k+2 regardless of travel. The block is then a pure converter, and the sequencer must pace commands itself.

## Structure
- Package servo_pkg:
  - ANGLE_MAX=180.
  - Width constants DUTY_W=20, GAP_W=12, TRAVEL_W=32.
  - State enum {IDLE, LOAD, MOVE}.
- Sub-module servo_travel_timer holds the 32-bit load/decrement counter and produces the zero flag. It is compiled only under SERVO_SETTLE_WAIT_EN.

## Test plan
- Reset check: assert rst for 2 cycles, then release.
  - duty_need=74_950, duty_gap=1, cmd_ready=1, busy=0, done=0, err=0.
- Angle 0, speed 1 from reset:
  - duty_need=25_000 at edge k+1.
  - done at edge k+2+49_950, err=0.
- Angle 200, speed 2 from 74_950:
  - duty_need=124_900, err=1.
  - travel=99_900, done at edge k+99_902.
  - The next valid angle-90 command clears err.
- Same angle twice, speed 0:
  - Second command gives duty_gap=1, done at edge k+2.
- cmd_valid held high during MOVE with changing angle:
  - Only the first command is accepted during MOVE.
  - The held command is accepted in the done cycle.
  - duty_need never changes while busy=1.
- rst pulsed 100 cycles into a long move:
  - Outputs return to reset values at the next edge.
  - No done pulse.
  - cmd_ready=1 at the edge after rst is released.

Source files
------------

// File: rtl/servo_cmd_pkg.sv
// servo_pkg: shared constants and types for the servo command front end.
//   ANGLE_MAX        - largest legal command angle in degrees.
//   DUTY_W / GAP_W   - widths of the high-time target and ramp step interval.
//   TRAVEL_W         - width of the settle-time counter (|delta duty| * gap).
//   state_e          - command FSM states.
package servo_pkg;

  localparam int ANGLE_MAX = 180;
  localparam int DUTY_W    = 20;
  localparam int GAP_W     = 12;
  localparam int TRAVEL_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MOVE = 2'd2
  } state_e;

endpackage

// File: rtl/servo_cmd_if.sv
// servo_cmd_if: command handshake bundle between the arm sequencer and
// one servo channel.
//   cmd_valid - command present (master -> slave)
//   cmd_ready - channel can accept a command (slave -> master)
//   cmd_angle - target angle in degrees, legal range 0..180
//   cmd_speed - counts between unit steps of the downstream ramp, 0 acts as 1
interface servo_cmd_if;
  import servo_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_angle;
  logic [GAP_W-1:0] cmd_speed;

  modport master (output cmd_valid, output cmd_angle, output cmd_speed, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_angle, input cmd_speed, output cmd_ready);

endinterface

// File: rtl/servo_travel_timer.sv
// servo_travel_timer: settle-time counter for servo_cmd.
//   clk      - system clock
//   rst      - synchronous active-high reset, clears the count
//   load     - load load_val (takes priority over dec)
//   dec      - decrement by one, saturating at zero
//   load_val - travel time in clock cycles
//   zero     - registered count is zero
module servo_travel_timer
  import servo_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                dec,
  input  logic [TRAVEL_W-1:0] load_val,
  output logic                zero
);

  logic [TRAVEL_W-1:0] cnt_q;
  logic [TRAVEL_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - TRAVEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/servo_cmd.sv
// servo_cmd: command front end for one servo channel.
// Accepts angle/speed commands, converts the angle into a 50 MHz-count
// high-time target for the pwm stage and, when SERVO_SETTLE_WAIT_EN is
// defined, holds off further commands until the ramp has had time to reach
// the new target (|delta duty| * gap cycles). Without the macro every move
// lasts a single cycle.
//   clk       - 50 MHz system clock
//   rst       - synchronous active-high reset
//   cmd       - command handshake (servo_cmd_if.slave)
//   duty_need - target high time to the pwm stage
//   duty_gap  - ramp step interval to the pwm stage
//   busy      - motion in progress
//   done      - one-cycle pulse when the move is considered complete
//   err       - last accepted command was out of range
module servo_cmd
  import servo_pkg::*;
#(
  parameter int DUTY_MIN     = 25_000,
  parameter int DUTY_PER_DEG = 555,
  parameter int ANGLE_RST    = 90
)
(
  input  logic              clk,
  input  logic              rst,
  servo_cmd_if.slave        cmd,
  output logic [DUTY_W-1:0] duty_need,
  output logic [GAP_W-1:0]  duty_gap,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [DUTY_W-1:0] DUTY_RST = DUTY_W'(DUTY_MIN + ANGLE_RST * DUTY_PER_DEG);

  state_e            state_q;
  logic [7:0]        angle_q;
  logic [GAP_W-1:0]  speed_q;
  logic [DUTY_W-1:0] duty_need_q;
  logic [GAP_W-1:0]  duty_gap_q;
  logic              cmd_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              angle_err;
  logic [7:0]        angle_clamped;
  logic [DUTY_W-1:0] new_duty;
  logic [GAP_W-1:0]  new_gap;
  logic              move_end;

  always_comb begin
    angle_err     = (angle_q > 8'(ANGLE_MAX));
    angle_clamped = angle_err ? 8'(ANGLE_MAX) : angle_q;
    new_duty      = DUTY_W'(DUTY_MIN) + DUTY_W'(angle_clamped) * DUTY_W'(DUTY_PER_DEG);
    new_gap       = (speed_q == '0) ? GAP_W'(1) : speed_q;
  end

`ifdef SERVO_SETTLE_WAIT_EN
  logic [DUTY_W-1:0]   duty_diff;
  logic [TRAVEL_W-1:0] travel;
  logic                cnt_zero;

  // Full 20x12 product in 32 bits; the largest travel fits without wrap.
  always_comb begin
    duty_diff = (new_duty >= duty_need_q) ? (new_duty - duty_need_q)
                                          : (duty_need_q - new_duty);
    travel    = TRAVEL_W'(duty_diff) * TRAVEL_W'(new_gap);
  end

  servo_travel_timer u_travel_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q == LOAD),
    .dec      (state_q == MOVE),
    .load_val (travel),
    .zero     (cnt_zero)
  );

  assign move_end = cnt_zero;
`else
  assign move_end = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      angle_q     <= '0;
      speed_q     <= '0;
      duty_need_q <= DUTY_RST;
      duty_gap_q  <= GAP_W'(1);
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd.cmd_valid && cmd_ready_q) begin
            angle_q     <= cmd.cmd_angle;
            speed_q     <= cmd.cmd_speed;
            cmd_ready_q <= 1'b0;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          duty_need_q <= new_duty;
          duty_gap_q  <= new_gap;
          err_q       <= angle_err;
          busy_q      <= 1'b1;
          state_q     <= MOVE;
        end
        MOVE: begin
          // move_end reflects the counter value loaded/decremented on
          // earlier edges, so zero travel finishes on the first MOVE edge.
          if (move_end) begin
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd.cmd_ready = cmd_ready_q;
  assign duty_need     = duty_need_q;
  assign duty_gap      = duty_gap_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_servo_cmd.sv
// tb_servo_cmd: directed self-checking bench for servo_cmd.
// Expected duty/gap/err/latency values come from the arithmetic in the
// command description; latency depends on SERVO_SETTLE_WAIT_EN.
module tb_servo_cmd;

  logic        clk;
  logic        rst;
  logic [19:0] duty_need;
  logic [11:0] duty_gap;
  logic        busy;
  logic        done;
  logic        err;

  servo_cmd_if cmd_bus ();

  servo_cmd dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd_bus),
    .duty_need (duty_need),
    .duty_gap  (duty_gap),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint exp_duty;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint duty_of(input int a);
    int ac;
    ac = (a > 180) ? 180 : a;
    return 64'(25_000 + ac * 555);
  endfunction

  function automatic longint latency_of(input longint old_d, input longint new_d, input int spd);
    longint diff;
    longint g;
    diff = (new_d > old_d) ? (new_d - old_d) : (old_d - new_d);
    g    = (spd == 0) ? 1 : spd;
`ifdef SERVO_SETTLE_WAIT_EN
    return 2 + diff * g;
`else
    if (diff * g < 0) return 0;
    return 2;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) until cmd_ready is seen, then steps past the handshake edge.
  task automatic wait_accept(input string tag);
    int n;
    n = 0;
    while (cmd_bus.cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (cmd_bus.cmd_ready !== 1'b1) chk({tag, " accept timeout"}, 0, 1);
    tick();
  endtask

  // Called just after handshake edge k; checks the load and completion timing.
  task automatic finish(input string tag, input int angle, input int speed);
    longint old_d, new_d, lat, n;
    int     g;
    bit     seen;
    old_d = exp_duty;
    new_d = duty_of(angle);
    g     = (speed == 0) ? 1 : speed;
    lat   = latency_of(old_d, new_d, speed);
    chk({tag, " duty before load"}, duty_need, old_d);
    chk({tag, " ready after accept"}, cmd_bus.cmd_ready, 0);
    tick();
    chk({tag, " duty_need"}, duty_need, new_d);
    chk({tag, " duty_gap"}, duty_gap, g);
    chk({tag, " err"}, err, (angle > 180) ? 1 : 0);
    chk({tag, " busy in move"}, busy, 1);
    n    = 1;
    seen = 0;
    while (!seen && n < lat + 8) begin
      tick();
      n++;
      if (done === 1'b1) seen = 1;
    end
    chk({tag, " done latency"}, seen ? n : -1, lat);
    chk({tag, " ready at done"}, cmd_bus.cmd_ready, 1);
    chk({tag, " busy at done"}, busy, 0);
    exp_duty = new_d;
    $display("cmd %-10s angle=%0d speed=%0d duty_need=%0d duty_gap=%0d err=%0d latency=%0d",
             tag, angle, speed, duty_need, duty_gap, err, n);
  endtask

  task automatic do_cmd(input string tag, input int angle, input int speed);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_angle = 8'(angle);
    cmd_bus.cmd_speed = 12'(speed);
    wait_accept(tag);
    cmd_bus.cmd_valid = 1'b0;
    finish(tag, angle, speed);
    tick();
    chk({tag, " done one cycle"}, done, 0);
  endtask

  initial begin
    int     viol;
    longint n, lat, nd;
    bit     seen;

    rst = 1'b1;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_angle = '0;
    cmd_bus.cmd_speed = '0;
    exp_duty = 74_950;

    // Reset for two cycles.
    tick();
    tick();
    rst = 1'b0;
    chk("rst duty_need", duty_need, 74_950);
    chk("rst duty_gap", duty_gap, 1);
    chk("rst cmd_ready", cmd_bus.cmd_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    $display("reset released duty_need=%0d", duty_need);

    do_cmd("ang0", 0, 1);
    do_cmd("ang90a", 90, 1);
    do_cmd("ang200", 200, 2);
    do_cmd("ang90b", 90, 1);
    do_cmd("same90", 90, 0);

    // Valid held through a move while the angle keeps changing.
    nd = duty_of(30);
    lat = latency_of(exp_duty, nd, 1);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_angle = 8'd30;
    cmd_bus.cmd_speed = 12'd1;
    wait_accept("held");
    n = 0;
    seen = 0;
    viol = 0;
    while (!seen && n < lat + 8) begin
      cmd_bus.cmd_angle = 8'(40 + (n % 100));
      tick();
      n++;
      if (busy === 1'b1 && duty_need !== 20'(nd)) viol++;
      if (done === 1'b1) seen = 1;
    end
    chk("held done latency", seen ? n : -1, lat);
    chk("held duty stable while busy", viol, 0);
    chk("held duty_need", duty_need, nd);
    $display("cmd %-10s angle=30 speed=1 duty_need=%0d latency=%0d", "held", duty_need, n);
    exp_duty = nd;
    // Still valid in the done cycle: this command must be taken at the next edge.
    cmd_bus.cmd_angle = 8'd120;
    cmd_bus.cmd_speed = 12'd3;
    tick();
    cmd_bus.cmd_valid = 1'b0;
    chk("held2 done one cycle", done, 0);
    finish("held2", 120, 3);
    tick();

    // Reset in the middle of a long move.
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_angle = 8'd250;
    cmd_bus.cmd_speed = 12'd4095;
    wait_accept("midrst");
    cmd_bus.cmd_valid = 1'b0;
    repeat (100) tick();
    rst = 1'b1;
    tick();
    chk("midrst duty_need", duty_need, 74_950);
    chk("midrst duty_gap", duty_gap, 1);
    chk("midrst cmd_ready", cmd_bus.cmd_ready, 1);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst err", err, 0);
    rst = 1'b0;
    tick();
    chk("midrst ready after release", cmd_bus.cmd_ready, 1);
    viol = 0;
    for (int i = 0; i < 30; i++) begin
      if (done !== 1'b0) viol++;
      tick();
    end
    chk("midrst no done", viol, 0);
    $display("cmd %-10s reset mid-move duty_need=%0d", "midrst", duty_need);
    exp_duty = 74_950;

    do_cmd("post", 45, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
